// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multicycle multiply/divide unit.
package multdiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StDone = 2'd3
    } md_state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of {B[0], q-1}.
    function automatic booth_op_e booth_recode(input logic [1:0] pair);
        booth_op_e op;
        case (pair)
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multdiv_unit_cla.sv
// Two-level carry-lookahead adder: 4-bit groups with lookahead across groups.
module multdiv_unit_cla #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic             cin_i,
    output logic [Width-1:0] sum_o,
    output logic             cout_o
);

    localparam int unsigned NumBlk = Width / 4;

    logic [Width-1:0]  g;
    logic [Width-1:0]  p;
    logic [Width-1:0]  c;
    logic [NumBlk-1:0] blk_g;
    logic [NumBlk-1:0] blk_p;
    logic [NumBlk-1:0] blk_c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        logic acc;
        blk_g = '0;
        blk_p = '0;
        blk_c = '0;
        c     = '0;
        acc   = 1'b0;
        for (int b = 0; b < int'(NumBlk); b++) begin
            acc = 1'b0;
            for (int k = 0; k < 4; k++) begin
                acc = g[4*b+k] | (p[4*b+k] & acc);
            end
            blk_g[b] = acc;
            blk_p[b] = &p[4*b +: 4];
        end
        for (int b = 0; b < int'(NumBlk); b++) begin
            acc = cin_i;
            for (int j = 0; j < b; j++) begin
                acc = blk_g[j] | (blk_p[j] & acc);
            end
            blk_c[b] = acc;
        end
        for (int b = 0; b < int'(NumBlk); b++) begin
            acc = blk_c[b];
            for (int k = 0; k < 4; k++) begin
                c[4*b+k] = acc;
                acc      = g[4*b+k] | (p[4*b+k] & acc);
            end
        end
    end

    assign sum_o  = p ^ c;
    assign cout_o = blk_g[NumBlk-1] | (blk_p[NumBlk-1] & blk_c[NumBlk-1]);

endmodule

// File: rtl/multdiv_unit.sv
// Multicycle signed multiplier (radix-2 Booth) and divider (non-restoring) sharing one adder.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CntW = $clog2(WIDTH);

    md_state_e        state_q;
    logic [CntW-1:0]  cnt_q;
    logic [2*WIDTH:0] prod_q;   // {P, B/quotient, q-1}
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] opnd_q;   // multiplicand, or divisor magnitude
    logic             neg_q;
    logic             is_div_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic             add_cin, add_cout, a_hi, b_hi;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   rem_shift;
    booth_op_e        booth_op;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH-1:0] fix_result;
    logic             fix_exc;

    multdiv_unit_cla #(
        .Width(WIDTH)
    ) u_cla (
        .a_i   (add_a),
        .b_i   (add_b),
        .cin_i (add_cin),
        .sum_o (add_sum),
        .cout_o(add_cout)
    );

    // Operand mux; the 33rd sum bit is rebuilt from the operands' extended top bits.
    always_comb begin
        booth_op  = booth_recode(prod_q[1:0]);
        rem_shift = {rem_q[WIDTH-1:0], prod_q[WIDTH]};
        add_a     = '0;
        add_b     = '0;
        add_cin   = 1'b0;
        a_hi      = 1'b0;
        b_hi      = 1'b0;
        unique case (state_q)
            StMul: begin
                add_a   = prod_q[2*WIDTH:WIDTH+1];
                add_b   = (booth_op == BOOTH_SUB) ? ~opnd_q :
                          (booth_op == BOOTH_ADD) ? opnd_q : '0;
                add_cin = (booth_op == BOOTH_SUB);
                a_hi    = prod_q[2*WIDTH];
                b_hi    = add_b[WIDTH-1];
            end
            StDiv: begin
                add_a   = rem_shift[WIDTH-1:0];
                add_b   = rem_q[WIDTH] ? opnd_q : ~opnd_q;
                add_cin = ~rem_q[WIDTH];
                a_hi    = rem_shift[WIDTH];
                b_hi    = ~rem_q[WIDTH];
            end
            StDone: begin
                // Remainder restore; the remainder is kept internal only.
                add_a = rem_q[WIDTH-1:0];
                add_b = (is_div_q && rem_q[WIDTH]) ? opnd_q : '0;
                a_hi  = rem_q[WIDTH];
            end
            default: ;
        endcase
        sum_ext = {a_hi ^ b_hi ^ add_cout, add_sum};
    end

    always_comb begin
        abs_a = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
        abs_b = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
        fix_result = prod_q[WIDTH:1];
        fix_exc    = 1'b0;
        if (!is_div_q) begin
            fix_exc = ~((&prod_q[2*WIDTH:WIDTH]) | ~(|prod_q[2*WIDTH:WIDTH]));
        end else if (opnd_q == '0) begin
            fix_result = '0;
            fix_exc    = 1'b1;
        end else if (neg_q) begin
            fix_result = ~prod_q[WIDTH:1] + WIDTH'(1);
        end else begin
            // Only 0x80000000 / -1 yields a positive magnitude of 2^(WIDTH-1).
            fix_exc = prod_q[WIDTH];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            neg_q    <= 1'b0;
            is_div_q <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            rdy_q <= 1'b0;
            if (ctrl_MULT || ctrl_DIV) begin
                cnt_q <= '0;
                rem_q <= '0;
                if (ctrl_MULT) begin
                    state_q  <= StMul;
                    is_div_q <= 1'b0;
                    neg_q    <= 1'b0;
                    opnd_q   <= data_operandA;
                    prod_q   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
                end else begin
                    state_q  <= StDiv;
                    is_div_q <= 1'b1;
                    neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    opnd_q   <= abs_b;
                    prod_q   <= {{WIDTH{1'b0}}, abs_a, 1'b0};
                end
            end else begin
                unique case (state_q)
                    StMul, StDiv: begin
                        if (state_q == StMul) begin
                            prod_q <= {sum_ext, prod_q[WIDTH:1]};
                        end else begin
                            rem_q            <= sum_ext;
                            prod_q[WIDTH:1]  <= {prod_q[WIDTH-1:1], ~sum_ext[WIDTH]};
                        end
                        if (cnt_q == CntW'(WIDTH - 1)) begin
                            state_q <= StDone;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StDone: begin
                        rem_q    <= sum_ext;
                        result_q <= fix_result;
                        exc_q    <= fix_exc;
                        rdy_q    <= 1'b1;
                        state_q  <= StIdle;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomized and directed checks of multdiv_unit against an arithmetic reference model.
module tb_multdiv_unit;

    logic        clock;
    logic        resetn;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_total;
    int n_bad;

    multdiv_unit dut (
        .clock         (clock),
        .resetn        (resetn),
        .data_operandA (data_operandA),
        .data_operandB (data_operandB),
        .ctrl_MULT     (ctrl_MULT),
        .ctrl_DIV      (ctrl_DIV),
        .data_result   (data_result),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Signed arithmetic on 64-bit integers; the divide rule truncates toward zero.
    function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint pa, pb, res;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (is_mul) begin
            res = pa * pb;
            r   = res[31:0];
            e   = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        end else if (pb == 0) begin
            r = 32'h0;
            e = 1'b1;
        end else begin
            res = pa / pb;
            r   = res[31:0];
            e   = (res > 64'sd2147483647);
        end
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0000_0000;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    task automatic run_op(input string tag, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ee;
        int          lat;
        lat = 0;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom();
        data_operandB = $urandom();
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) lat = i;
        end
        model(m, a, b, er, ee);
        check({tag, ":lat"}, 64'(lat), 64'd33);
        check({tag, ":res"}, 64'(data_result), 64'(er));
        check({tag, ":exc"}, 64'(data_exception), 64'(ee));
        @(posedge clock);
        #1;
        check({tag, ":rdy_pulse"}, 64'(data_resultRDY), 64'd0);
        check({tag, ":hold"}, 64'({data_exception, data_result}), 64'({ee, er}));
    endtask

    initial begin
        logic [31:0] er;
        logic        ee;
        int          rdy_cnt;
        int          lat;
        logic [31:0] res_seen;
        logic        exc_seen;

        n_total       = 0;
        n_bad         = 0;
        resetn        = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        #3;
        check("reset_out", 64'({data_resultRDY, data_exception, data_result}), 64'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;

        run_op("mul_7_m3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        run_op("mul_min", 1'b1, 1'b0, 32'h8000_0000, 32'd1);
        run_op("div_m20_3", 1'b0, 1'b1, 32'hFFFF_FFEC, 32'd3);
        run_op("div_100_m7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        run_op("div_by0", 1'b0, 1'b1, 32'd5, 32'd0);
        run_op("mul_div_both", 1'b1, 1'b1, 32'd6, 32'd2);

        // Restart: divide pulse 10 cycles into a multiply.
        rdy_cnt  = 0;
        lat      = 0;
        res_seen = '0;
        exc_seen = 1'b0;
        @(negedge clock);
        data_operandA = 32'd3;
        data_operandB = 32'd4;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        @(negedge clock);
        data_operandA = 32'd9;
        data_operandB = 32'd2;
        ctrl_DIV      = 1'b1;
        @(posedge clock);
        #1;
        ctrl_DIV = 1'b0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                rdy_cnt++;
                if (lat == 0) begin
                    lat      = i;
                    res_seen = data_result;
                    exc_seen = data_exception;
                end
            end
        end
        model(1'b0, 32'd9, 32'd2, er, ee);
        check("restart:rdy_count", 64'(rdy_cnt), 64'd1);
        check("restart:lat", 64'(lat), 64'd33);
        check("restart:res", 64'({exc_seen, res_seen}), 64'({ee, er}));

        // Reset in the middle of a multiply, with nonzero outputs held beforehand.
        run_op("div_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        @(negedge clock);
        data_operandA = 32'd123;
        data_operandB = 32'd456;
        ctrl_MULT     = 1'b1;
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        repeat (14) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        check("midreset_out", 64'({data_resultRDY, data_exception, data_result}), 64'd0);
        repeat (2) @(negedge clock);
        resetn  = 1'b1;
        rdy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_cnt++;
        end
        check("midreset:no_rdy", 64'(rdy_cnt), 64'd0);
        run_op("mul_2_2", 1'b1, 1'b0, 32'd2, 32'd2);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] ra, rb;
            bit          rm;
            ra = pick();
            rb = pick();
            rm = 1'($urandom_range(0, 1));
            run_op($sformatf("rand%0d_%s", n, rm ? "mul" : "div"), rm, !rm, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
